// File: rtl/lsu_bank_group_port.sv
// lsu_bank_group_port: per-bank-group request FIFO and single-port SRAM sequencer
// with in-order issue and a one-entry registered read response.
`default_nettype none

module lsu_bank_group_port #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_rd_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_data_o,
    output logic          busy_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_STALL   = 2'd3
    } state_e;

    logic          fifo_rd_q    [DEPTH];
    logic [AW-1:0] fifo_addr_q  [DEPTH];
    logic [DW-1:0] fifo_wdata_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;

    logic   empty, head_rd, rd_ok, push, issue;
    state_e state;

    assign empty   = (count_q == '0);
    assign head_rd = fifo_rd_q[rd_ptr_q];
    // A read may only launch when its response register will be free on capture.
    assign rd_ok   = !rd_inflight_q && (!rsp_valid_q || rsp_ready_i);
    assign push    = req_valid_i && req_ready_o;

    always_comb begin
        state = S_IDLE;
        if (empty)
            state = rd_inflight_q ? S_RD_WAIT : S_IDLE;
        else if (head_rd && !rd_ok)
            state = S_STALL;
        else if (rd_inflight_q)
            state = S_RD_WAIT;
        else
            state = S_ISSUE;
    end

    assign issue         = !empty && ((state == S_ISSUE) || (state == S_RD_WAIT));
    assign rd_inflight_d = issue && head_rd;

    always_comb begin
        count_d = count_q;
        case ({push, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign req_ready_o = (count_q < FULL_CNT);
    assign mem_en_o    = issue;
    assign mem_we_o    = issue && !head_rd;
    assign mem_addr_o  = issue ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_wdata_o = issue ? fifo_wdata_q[rd_ptr_q] : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = !empty || rd_inflight_q || rsp_valid_q;

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]    <= req_rd_i;
            fifo_addr_q[wr_ptr_q]  <= req_addr_i;
            fifo_wdata_q[wr_ptr_q] <= req_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (issue)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // Capture beats a same-cycle handshake, so a fresh response is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (rd_inflight_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mem_rdata_i;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bank_group_port.sv
// tb_lsu_bank_group_port: directed vector table, corner sequences and random traffic
// checked against a queue-based transaction model with its own SRAM.
`default_nettype none

module tb_lsu_bank_group_port;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_rd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          req_ready, mem_en, mem_we, rsp_valid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rsp_data;

    lsu_bank_group_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_i(req_rd),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    typedef struct { logic rd; logic [AW-1:0] addr; logic [DW-1:0] wd; } req_t;
    typedef struct { logic [DW-1:0] d; int avail; } rsp_t;
    req_t          pend [$];
    rsp_t          rspq [$];
    logic [DW-1:0] mmem [1024];
    bit            last_rd = 1'b0;
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    typedef struct {
        logic vld; logic rd; logic [AW-1:0] addr; logic [DW-1:0] wd; logic rr;
        logic e_ready; logic e_en; logic e_we; logic [AW-1:0] e_addr;
        logic e_rv; logic [DW-1:0] e_data;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        rspq.delete();
        last_rd = 1'b0;
    endtask

    task automatic drive(input logic v, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        @(negedge clk);
        req_valid = v; req_rd = r; req_addr = a; req_wdata = d; rsp_ready = rr;
        #1;
    endtask

    // Expected behaviour from the transaction rules: FIFO order, one access per
    // cycle, reads wait for a free response slot and appear two cycles after issue.
    task automatic model_cycle();
        bit   exp_ready, exp_rv, exp_en, hr;
        req_t r;
        exp_ready = pend.size() < DEPTH;
        exp_rv    = (rspq.size() > 0) && (rspq[0].avail <= cyc);
        hr        = (pend.size() > 0) ? pend[0].rd : 1'b0;
        exp_en    = (pend.size() > 0) && (!hr || (!last_rd && (!exp_rv || rsp_ready)));
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        chk("mem_en", {31'b0, mem_en}, {31'b0, exp_en});
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_en && !hr});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rv});
        chk("busy", {31'b0, busy}, {31'b0, (pend.size() > 0) || (rspq.size() > 0)});
        if (exp_en) begin
            chk("mem_addr", {22'b0, mem_addr}, {22'b0, pend[0].addr});
            if (!hr) chk("mem_wdata", mem_wdata, pend[0].wd);
        end
        if (exp_rv) chk("rsp_data", rsp_data, rspq[0].d);
        last_rd = exp_en && hr;
        if (exp_en) begin
            r = pend.pop_front();
            if (!r.rd) mmem[r.addr] = r.wd;
            else       rspq.push_back('{mmem[r.addr], cyc + 2});
        end
        if (exp_rv && rsp_ready) void'(rspq.pop_front());
        if (req_valid && exp_ready) pend.push_back('{req_rd, req_addr, req_wdata});
        cyc++;
        @(posedge clk);
    endtask

    task automatic cyc_run(input logic v, input logic r, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic rr);
        drive(v, r, a, d, rr);
        model_cycle();
    endtask

    task automatic push_req(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = pend.size() < DEPTH;
            cyc_run(1'b1, r, a, d, 1'b1);
        end
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL push_timeout: got no accept expected accept");
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((pend.size() > 0 || rspq.size() > 0) && guard < 200) begin
            cyc_run(1'b0, 1'b0, '0, '0, 1'b1);
            guard++;
        end
        if (guard >= 200) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", pend.size() + rspq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i] = '0;
            mmem[i] = '0;
        end
        tbl[0]  = '{1, 0, 10'h005, 32'hDEADBEEF, 1, 1, 0, 0, 10'h000, 0, 32'h0};
        tbl[1]  = '{1, 1, 10'h005, 32'h0,        1, 1, 1, 1, 10'h005, 0, 32'h0};
        tbl[2]  = '{0, 0, 10'h000, 32'h0,        1, 1, 1, 0, 10'h005, 0, 32'h0};
        tbl[3]  = '{0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 10'h000, 0, 32'h0};
        tbl[4]  = '{0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 10'h000, 1, 32'hDEADBEEF};
        tbl[5]  = '{0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 10'h000, 0, 32'h0};
        tbl[6]  = '{1, 0, 10'h00A, 32'h11111111, 1, 1, 0, 0, 10'h000, 0, 32'h0};
        tbl[7]  = '{1, 1, 10'h00A, 32'h0,        1, 1, 1, 1, 10'h00A, 0, 32'h0};
        tbl[8]  = '{1, 0, 10'h00B, 32'h22222222, 1, 1, 1, 0, 10'h00A, 0, 32'h0};
        tbl[9]  = '{1, 1, 10'h00B, 32'h0,        1, 1, 1, 1, 10'h00B, 0, 32'h0};
        tbl[10] = '{0, 0, 10'h000, 32'h0,        1, 1, 1, 0, 10'h00B, 1, 32'h11111111};
        tbl[11] = '{0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 10'h000, 0, 32'h0};
        tbl[12] = '{0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 10'h000, 1, 32'h22222222};

        #7;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write/read to 0x005, then interleaved W,R,W,R with RD_WAIT write issue.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].rr);
            chk("tbl_req_ready", {31'b0, req_ready}, {31'b0, tbl[i].e_ready});
            chk("tbl_mem_en", {31'b0, mem_en}, {31'b0, tbl[i].e_en});
            chk("tbl_mem_we", {31'b0, mem_we}, {31'b0, tbl[i].e_we});
            if (tbl[i].e_en) chk("tbl_mem_addr", {22'b0, mem_addr}, {22'b0, tbl[i].e_addr});
            chk("tbl_rsp_valid", {31'b0, rsp_valid}, {31'b0, tbl[i].e_rv});
            if (tbl[i].e_rv) chk("tbl_rsp_data", rsp_data, tbl[i].e_data);
            model_cycle();
        end

        // Fill with responses blocked: the FIFO saturates and extra requests bounce.
        for (int i = 0; i < 8; i++)
            cyc_run(1'b1, 1'b1, 10'(i), '0, 1'b0);
        drive(1'b1, 1'b1, 10'h3FF, '0, 1'b0);
        chk("fill_req_ready_low", {31'b0, req_ready}, 32'h0);
        model_cycle();
        for (int i = 0; i < 5; i++)
            cyc_run(1'b0, 1'b0, '0, '0, 1'b0);
        drain();

        // Pointer wrap: ten writes then ten reads of the same addresses.
        for (int i = 0; i < 10; i++) push_req(1'b0, 10'(i), 32'(i));
        for (int i = 0; i < 10; i++) push_req(1'b1, 10'(i), '0);
        drain();

        // Reset with three reads queued and one in flight.
        for (int i = 0; i < 6; i++)
            cyc_run(1'b1, 1'b1, 10'(i), '0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("midrst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_cycle();
        for (int i = 0; i < 5; i++)
            cyc_run(1'b0, 1'b0, '0, '0, 1'b1);

        // Random traffic over a small address window.
        for (int i = 0; i < 400; i++)
            cyc_run(1'($urandom % 2), 1'($urandom % 2), 10'($urandom % 16),
                    $urandom, 1'(($urandom % 4) != 0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_bank_group_port.md
# lsu_bank_group_port

Per-bank-group request port sitting directly downstream of the 4x4 LSU-to-bank-group crossbar: one instance per bank group, consuming that group's routed request (write data, read flag, address) and driving the group's single-port SRAM. It buffers requests in an in-order FIFO, sequences SRAM reads and writes, and returns read data as the group's read response, which the crossbar routes back to the requesting LSU.

## Interface
- AW, 10, bank-group word address width (matches crossbar address output width)
- DW, 32, data width of write data and read response
- DEPTH, 4, request FIFO depth; power of 2, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  crossbar presents a request
- req_ready  out  1  port can accept a request this cycle
- req_rd  in  1  1 = read, 0 = write
- req_addr  in  AW  word address
- req_wdata  in  DW  write data (ignored for reads)
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable (meaningful only with mem_en)
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid the cycle after a read strobe
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  crossbar/LSU accepts response
- rsp_data  out  DW  read response data
- busy  out  1  FIFO non-empty, read in flight, or rsp_valid high

## Operation
- Push: request enqueued on rising edge when req_valid && req_ready. req_ready = (count < DEPTH), registered count only; no pop-through when full.
- FIFO: circular, wr/rd pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- Issue, strictly in FIFO order, at most one SRAM access per cycle, head popped in issue cycle:
  - write head: issues whenever FIFO non-empty (rd_inflight does not block writes).
  - read head: issues only if !rd_inflight && (!rsp_valid || rsp_ready).
- Issue cycle drives mem_en=1, mem_we=!rd, mem_addr/mem_wdata from head, combinationally from registered FIFO state. No issue: mem_en=0, mem_we=0, address/data don't-care.
- Read return: rd_inflight set on read issue, cleared next cycle; in that cycle mem_rdata registered into rsp_data, rsp_valid set.
- rsp_valid cleared on rsp_valid && rsp_ready unless new data captured same cycle (capture wins, rsp_valid stays 1). rsp_data stable while rsp_valid && !rsp_ready.
- Issue FSM (state derived from registered flags):
  - IDLE: FIFO empty, no read in flight.
  - ISSUE: head issuable.
  - RD_WAIT: read in flight; write head may still issue.
  - STALL: head is read, blocked by rd_inflight or held response.
  - Transitions evaluated every cycle from FIFO count, head type, rd_inflight, rsp_valid, rsp_ready.
- Reset (any time, incl. mid-read): pointers/count 0, rd_inflight 0, rsp_valid 0, rsp_data 0; in-flight read data discarded.

## Timing
- Reset values: req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, busy=0.
- Request accepted at edge E0 -> earliest issue cycle after E0 (one cycle FIFO latency).
- Read: issue cycle N -> mem_rdata cycle N+1 -> rsp_valid high from cycle N+2.
- Throughput: writes 1/cycle; back-to-back reads 1 per 2 cycles with rsp_ready=1.
- Full FIFO with pop same cycle: req_ready still 0 that cycle, 1 next cycle.

## Test plan
- Reset mid-operation: 3 reads queued, one in flight, assert rst -> rsp_valid=0, req_ready=1, mem_en=0 immediately; after release no stale response appears.
- Single write then read: write addr 0x005 data 0xDEADBEEF, read addr 0x005 -> mem_en/mem_we=1 cycle after accept, then read strobe next cycle, rsp_data=0xDEADBEEF with rsp_valid 2 cycles after read strobe.
- Fill to DEPTH=4 with rsp_ready=0 and reads queued -> req_ready=0 after 4th accept, 5th request not accepted; FIFO drains in order once rsp_ready=1.
- Backpressure: 2 reads, rsp_ready=0 for 5 cycles -> first response held stable, second read not issued (STALL); releases with data in original order.
- Interleave W,R,W,R to alternating addresses with rsp_ready=1 -> issue order matches push order, write issued in RD_WAIT cycle, read data reflects prior write.
- Pointer wrap: 10 sequential writes addr 0..9 then 10 reads -> all data 0..9 returned correctly across pointer wrap-around.
